// File: rtl/utim64_irq_sched.sv
// Interrupt scheduler for the four UTIM64 comparator IRQs: edge detect, pending/overrun
// latching, fixed or round-robin arbitration, and a valid/ack handshake to the core.
module utim64_irq_sched #(
  parameter logic P_RR_DEFAULT = 1'b0
) (
  input  logic       iTIMER_CLOCK,
  input  logic       inRESET,
  input  logic [3:0] iCMP_IRQ,
  input  logic       iCONF_WRITE,
  input  logic [3:0] iCONF_MASK,
  input  logic       iCONF_RR,
  input  logic       iCLEAR_VALID,
  input  logic [3:0] iCLEAR_MASK,
  output logic       oIRQ_VALID,
  output logic [1:0] oIRQ_NUM,
  input  logic       iIRQ_ACK,
  output logic [3:0] oPENDING,
  output logic [3:0] oOVERRUN
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_prev;
  logic [3:0] r_pending;
  logic [3:0] r_overrun;
  logic [3:0] r_mask;
  logic       r_rr;
  logic [1:0] r_ptr;
  logic [1:0] r_num;

  logic [3:0] w_event;
  logic       w_ack;
  logic [3:0] w_ack_vec;
  logic [3:0] w_clr_vec;
  logic [3:0] w_cand;
  logic [3:0] w_pending_nxt;
  logic [3:0] w_overrun_nxt;
  logic [1:0] w_base;
  logic [1:0] w_idx;
  logic [1:0] w_winner;
  logic       w_found;

  assign w_event   = iCMP_IRQ & ~r_prev;
  assign w_ack     = (r_state == ST_REQ) && iIRQ_ACK;
  assign w_ack_vec = w_ack ? (4'b0001 << r_num) : '0;
  assign w_clr_vec = iCLEAR_VALID ? iCLEAR_MASK : '0;
  assign w_cand    = r_pending & r_mask;

  // An event always wins over ack/clear for pending; clear wins over overrun.
  always_comb begin
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_event[i[1:0]]) begin
        w_pending_nxt[i[1:0]] = 1'b1;
        if (w_clr_vec[i[1:0]])
          w_overrun_nxt[i[1:0]] = 1'b0;
        else if (r_pending[i[1:0]] && !w_ack_vec[i[1:0]])
          w_overrun_nxt[i[1:0]] = 1'b1;
      end else begin
        if (w_ack_vec[i[1:0]] || w_clr_vec[i[1:0]])
          w_pending_nxt[i[1:0]] = 1'b0;
        if (w_clr_vec[i[1:0]])
          w_overrun_nxt[i[1:0]] = 1'b0;
      end
    end
  end

  // Fixed priority is the round-robin search with the start point pinned at channel 0.
  assign w_base = r_rr ? r_ptr : '0;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = w_base + i[1:0];
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_REQ;
      ST_REQ:  if (iIRQ_ACK) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state   <= ST_IDLE;
      r_prev    <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_mask    <= '0;
      r_rr      <= P_RR_DEFAULT;
      r_ptr     <= '0;
      r_num     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= iCMP_IRQ;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      if (iCONF_WRITE) begin
        r_mask <= iCONF_MASK;
        r_rr   <= iCONF_RR;
      end
      if (r_state == ST_IDLE && w_found)
        r_num <= w_winner;
      if (w_ack)
        r_ptr <= r_num + 2'd1;
    end
  end

  assign oIRQ_VALID = (r_state == ST_REQ);
  assign oIRQ_NUM   = r_num;
  assign oPENDING   = r_pending;
  assign oOVERRUN   = r_overrun;

endmodule

// File: tb/tb_utim64_irq_sched.sv
// Bench for utim64_irq_sched: cycle table with scoreboard plus handshake/arbitration sequences.
module tb_utim64_irq_sched;

  logic       clk = 1'b0;
  logic       inRESET;
  logic [3:0] iCMP_IRQ;
  logic       iCONF_WRITE;
  logic [3:0] iCONF_MASK;
  logic       iCONF_RR;
  logic       iCLEAR_VALID;
  logic [3:0] iCLEAR_MASK;
  logic       oIRQ_VALID;
  logic [1:0] oIRQ_NUM;
  logic       iIRQ_ACK;
  logic [3:0] oPENDING;
  logic [3:0] oOVERRUN;

  always #5 clk = ~clk;

  utim64_irq_sched #(.P_RR_DEFAULT(1'b0)) dut (
    .iTIMER_CLOCK (clk),
    .inRESET      (inRESET),
    .iCMP_IRQ     (iCMP_IRQ),
    .iCONF_WRITE  (iCONF_WRITE),
    .iCONF_MASK   (iCONF_MASK),
    .iCONF_RR     (iCONF_RR),
    .iCLEAR_VALID (iCLEAR_VALID),
    .iCLEAR_MASK  (iCLEAR_MASK),
    .oIRQ_VALID   (oIRQ_VALID),
    .oIRQ_NUM     (oIRQ_NUM),
    .iIRQ_ACK     (iIRQ_ACK),
    .oPENDING     (oPENDING),
    .oOVERRUN     (oOVERRUN)
  );

  typedef struct {
    logic [3:0] cmp;
    logic       cw;
    logic [3:0] cm;
    logic       crr;
    logic       clv;
    logic [3:0] clm;
    logic       ack;
    logic       ev;
    logic [1:0] en;
    logic [3:0] ep;
    logic [3:0] eo;
  } vec_t;

  vec_t vt[22];
  vec_t sb_q[$];
  int   num_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] cmp, input logic cw, input logic [3:0] cm,
                              input logic clv, input logic [3:0] clm, input logic ack,
                              input logic ev, input logic [1:0] en, input logic [3:0] ep,
                              input logic [3:0] eo);
    vec_t v;
    v.cmp = cmp; v.cw = cw; v.cm = cm; v.crr = 1'b0; v.clv = clv; v.clm = clm; v.ack = ack;
    v.ev = ev; v.en = en; v.ep = ep; v.eo = eo;
    return v;
  endfunction

  task automatic idle_inputs();
    iCMP_IRQ = '0; iCONF_WRITE = 1'b0; iCONF_MASK = '0; iCONF_RR = 1'b0;
    iCLEAR_VALID = 1'b0; iCLEAR_MASK = '0; iIRQ_ACK = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 inRESET = 1'b0;
    step();
    step();
    inRESET = 1'b1;
  endtask

  task automatic config_write(input logic [3:0] mask, input logic rr);
    iCONF_WRITE = 1'b1; iCONF_MASK = mask; iCONF_RR = rr;
    step();
    iCONF_WRITE = 1'b0;
  endtask

  // Waits for a request, compares its number against the queue head, then acks it,
  // optionally raising comparator lines in the same cycle as the ack.
  task automatic serve(input string nm, input logic [3:0] retrig, input bit chk_gap);
    int unsigned waited = 0;
    int exp_num;
    while (!oIRQ_VALID && waited < 20) begin
      step();
      waited++;
    end
    check({nm, " valid"}, int'(oIRQ_VALID), 1);
    exp_num = (num_q.size() != 0) ? num_q.pop_front() : -1;
    check({nm, " num"}, int'(oIRQ_NUM), exp_num);
    if (chk_gap) check({nm, " gap"}, int'(waited), 2);
    iIRQ_ACK = 1'b1;
    iCMP_IRQ = retrig;
    step();
    iIRQ_ACK = 1'b0;
    iCMP_IRQ = '0;
    check({nm, " drop"}, int'(oIRQ_VALID), 0);
  endtask

  initial begin
    vec_t e;
    logic [3:0] rr_retrig[8];
    int unsigned hi_seen;

    vt[0]  = mk(4'h0, 1, 4'hF, 0, 4'h0, 0,  0, 0, 4'h0, 4'h0);
    vt[1]  = mk(4'h4, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h4, 4'h0);
    vt[2]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  1, 2, 4'h4, 4'h0);
    vt[3]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  1, 2, 4'h4, 4'h0);
    vt[4]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h0, 4'h0);
    vt[5]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h0, 4'h0);
    vt[6]  = mk(4'h2, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h2, 4'h0);
    vt[7]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  1, 1, 4'h2, 4'h0);
    vt[8]  = mk(4'h2, 0, 4'h0, 0, 4'h0, 0,  1, 1, 4'h2, 4'h2);
    vt[9]  = mk(4'h0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h0, 4'h2);
    vt[10] = mk(4'h0, 0, 4'h0, 1, 4'h2, 0,  0, 0, 4'h0, 4'h0);
    vt[11] = mk(4'h2, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h2, 4'h0);
    vt[12] = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  1, 1, 4'h2, 4'h0);
    vt[13] = mk(4'h2, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h2, 4'h0);
    vt[14] = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h2, 4'h0);
    vt[15] = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  1, 1, 4'h2, 4'h0);
    vt[16] = mk(4'h2, 0, 4'h0, 1, 4'h2, 0,  1, 1, 4'h2, 4'h0);
    vt[17] = mk(4'h0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 4'h0, 4'h0);
    vt[18] = mk(4'h0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h0, 4'h0);
    vt[19] = mk(4'h0, 1, 4'h0, 0, 4'h0, 0,  0, 0, 4'h0, 4'h0);
    vt[20] = mk(4'h1, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h1, 4'h0);
    vt[21] = mk(4'h1, 0, 4'h0, 0, 4'h0, 0,  0, 0, 4'h1, 4'h0);

    idle_inputs();
    inRESET = 1'b0;
    step();
    check("rst valid", int'(oIRQ_VALID), 0);
    check("rst num", int'(oIRQ_NUM), 0);
    check("rst pend", int'(oPENDING), 0);
    check("rst ovr", int'(oOVERRUN), 0);
    step();
    inRESET = 1'b1;

    for (int i = 0; i < 22; i++) begin
      iCMP_IRQ = vt[i].cmp; iCONF_WRITE = vt[i].cw; iCONF_MASK = vt[i].cm;
      iCONF_RR = vt[i].crr; iCLEAR_VALID = vt[i].clv; iCLEAR_MASK = vt[i].clm;
      iIRQ_ACK = vt[i].ack;
      sb_q.push_back(vt[i]);
      step();
      e = sb_q.pop_front();
      check($sformatf("v%0d valid", i), int'(oIRQ_VALID), int'(e.ev));
      if (e.ev) check($sformatf("v%0d num", i), int'(oIRQ_NUM), int'(e.en));
      check($sformatf("v%0d pend", i), int'(oPENDING), int'(e.ep));
      check($sformatf("v%0d ovr", i), int'(oOVERRUN), int'(e.eo));
    end
    iCONF_WRITE = 1'b0; iCLEAR_VALID = 1'b0; iIRQ_ACK = 1'b0;

    // Masked ch0 stays pending without a request; unmasking grants it two edges later.
    hi_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oIRQ_VALID) hi_seen++;
    end
    check("mask hold valid", int'(hi_seen), 0);
    check("mask hold pend", int'(oPENDING), 1);
    config_write(4'h1, 1'b0);
    check("unmask +1 valid", int'(oIRQ_VALID), 0);
    step();
    check("unmask +2 valid", int'(oIRQ_VALID), 1);
    check("unmask +2 num", int'(oIRQ_NUM), 0);

    // Masked ch3 fires twice during the ch0 request, then reset lands between edges.
    iCMP_IRQ = 4'b1001; step();
    iCMP_IRQ = 4'b0001; step();
    iCMP_IRQ = 4'b1001; step();
    check("pre-rst ovr", int'(oOVERRUN), 8);
    check("pre-rst valid", int'(oIRQ_VALID), 1);
    #3 inRESET = 1'b0;
    #1;
    check("async rst valid", int'(oIRQ_VALID), 0);
    check("async rst pend", int'(oPENDING), 0);
    check("async rst ovr", int'(oOVERRUN), 0);
    #2 inRESET = 1'b1;
    step();
    check("post-rst event", int'(oPENDING), 9);

    do_reset();
    config_write(4'hF, 1'b0);
    iCMP_IRQ = 4'b1011;
    num_q.push_back(0); num_q.push_back(1); num_q.push_back(3);
    step();
    iCMP_IRQ = '0;
    serve("fix g0", 4'h0, 1'b0);
    serve("fix g1", 4'h0, 1'b1);
    serve("fix g2", 4'h0, 1'b1);
    check("fix done pend", int'(oPENDING), 0);

    do_reset();
    config_write(4'hF, 1'b1);
    rr_retrig[0] = 4'b0001; rr_retrig[1] = 4'b0010; rr_retrig[2] = 4'b0100;
    rr_retrig[3] = 4'b1000; rr_retrig[4] = 4'b0000; rr_retrig[5] = 4'b0000;
    rr_retrig[6] = 4'b1010; rr_retrig[7] = 4'b0000;
    for (int i = 0; i < 8; i++) num_q.push_back(i % 4);
    iCMP_IRQ = 4'hF;
    step();
    iCMP_IRQ = '0;
    for (int i = 0; i < 8; i++)
      serve($sformatf("rr g%0d", i), rr_retrig[i], i != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/utim64_irq_sched.md
Name: utim64_irq_sched

Overview:
- Interrupt scheduler between the four UTIM64 comparator IRQ lines and the core interrupt input.
- Edge-detects each comparator IRQ and latches it as pending, with per-channel masking.
- Arbitrates among the pending channels (fixed or round-robin) and presents exactly one interrupt number at a time.
- Holds that interrupt under a valid/ack handshake; all logic runs in the timer clock domain.

Parameters:
- P_RR_DEFAULT, 0, reset value of the arbitration mode: 0 = fixed priority (ch0 highest), 1 = round-robin.

Ports:
- iTIMER_CLOCK  in  1  timer clock; all state updates on its rising edge
- inRESET  in  1  reset, asynchronous, active-low
- iCMP_IRQ  in  4  comparator IRQ lines; bit n = comparator n
- iCONF_WRITE  in  1  one-cycle strobe that loads the mask register and the mode bit
- iCONF_MASK  in  4  channel enable; 1 = channel may be issued
- iCONF_RR  in  1  arbitration mode to load
- iCLEAR_VALID  in  1  one-cycle strobe for a software pending/overrun clear
- iCLEAR_MASK  in  4  channels to clear
- oIRQ_VALID  out  1  interrupt request to the core
- oIRQ_NUM  out  2  channel number of the current request
- iIRQ_ACK  in  1  core acknowledge; meaningful only while oIRQ_VALID = 1
- oPENDING  out  4  pending register, unmasked view
- oOVERRUN  out  4  sticky overrun flags

Behaviour:
- Reset (asynchronous, inRESET = 0) clears everything:
  - oIRQ_VALID = 0, oIRQ_NUM = 0, oPENDING = 0, oOVERRUN = 0
  - mask = 4'h0, mode = P_RR_DEFAULT, round-robin pointer = 0
  - the previous-sample register of iCMP_IRQ = 0
  - FSM = IDLE
  - Reset applies mid-handshake as well; the request is dropped, no ack is needed.
- Edge detect: event[n] = iCMP_IRQ[n] & ~prev[n]; prev is updated every cycle.
  - A level held high produces exactly one event.
- Pending update, per channel, each cycle:
  - event[n]: set pending[n]. If pending[n] was already 1 and is not being acked this cycle, set overrun[n].
  - Ack of channel n (not in the same cycle as an event on n): clear pending[n].
  - event and ack on the same channel in the same cycle: pending stays 1, overrun not set.
  - iCLEAR_VALID: clear pending[n] and overrun[n] wherever iCLEAR_MASK[n] = 1.
  - event and clear on the same channel in the same cycle: the event wins (pending = 1); overrun is cleared.
- Masking:
  - Masked channels still latch pending and overrun but are never arbitrated.
  - Unmasking a pending channel makes it eligible on the next cycle.
- Config write: iCONF_WRITE loads mask and mode at the clock edge.
  - It does not retract or change an in-flight request.
- Arbitration: candidates = pending & mask.
  - Fixed priority: lowest index wins.
  - Round-robin: first candidate at or after pointer, searching upward with wrap 3 -> 0.
    - On each ack, pointer = granted number + 1 (mod 4).
    - The pointer is kept, not reset, when the mode changes.
- FSM:
  - IDLE: if candidates != 0, latch the winner into oIRQ_NUM, set oIRQ_VALID = 1, go to REQ. Otherwise stay.
  - REQ: oIRQ_VALID and oIRQ_NUM are held stable until iIRQ_ACK = 1.
    - On ack: clear pending[oIRQ_NUM] (subject to the same-cycle rules above), oIRQ_VALID = 0, update pointer, go to GAP.
    - A software clear of the in-flight channel does not cancel the request; the core still acks it.
  - GAP: one idle cycle with oIRQ_VALID = 0, then IDLE.
    - This guarantees at least one low cycle between consecutive requests.
- Latency:
  - iCMP_IRQ rises in cycle N: pending is set after edge N; oIRQ_VALID = 1 after edge N+1.
  - Ack in cycle M: oIRQ_VALID = 0 after edge M; the next request is valid after edge M+2 at the earliest.
- iIRQ_ACK while oIRQ_VALID = 0 is ignored.

Test Plan:
- Basic timing: mask = 4'hF; pulse iCMP_IRQ[2] high for one cycle at cycle 10 -> oPENDING = 4'b0100 at 11; oIRQ_VALID = 1 with oIRQ_NUM = 2 at 12. Ack at 15 -> oIRQ_VALID = 0 and oPENDING = 0 at 16.
- Fixed priority: mask = 4'hF, mode = 0; raise channels 3, 1, 0 together -> grants in order 0, 1, 3, with exactly one GAP cycle between each ack and the next oIRQ_VALID.
- Round-robin: mode = 1; keep all four channels re-triggering -> grant sequence 0, 1, 2, 3, 0. Then grant 2 and re-raise channels 1 and 3 -> the next grant is 3.
- Overrun and collisions:
  - Event on ch1 while pending[1] = 1 and not acked -> oOVERRUN[1] = 1.
  - Event on ch1 in the ack cycle of ch1 -> pending stays 1, no overrun.
  - Event and clear on ch1 in the same cycle -> pending = 1, overrun = 0.
- Masking: mask = 0; raise ch0 -> oPENDING[0] = 1, oIRQ_VALID stays 0 for 20 cycles. Write mask = 4'h1 -> oIRQ_VALID = 1 with oIRQ_NUM = 0 two cycles after the write.
- Reset mid-handshake: while in REQ, pulse inRESET low asynchronously between clock edges -> oIRQ_VALID, oPENDING and oOVERRUN drop to 0 immediately. After release, a held-high iCMP_IRQ produces a new event, because prev was cleared to 0.
